// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit field positions and counter helpers for the NoC endpoint
package noc_pkg;

  localparam int CountWidth = 16;

  function automatic int addr_msb(input int data_width, input int addr_width);
    return data_width + addr_width - 1;
  endfunction

  function automatic int addr_lsb(input int data_width);
    return data_width;
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/pe_ep_fifo.sv
// rtl/pe_ep_fifo.sv - first-word-fall-through FIFO; full blocks push even when a pop coincides
module pe_ep_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             empty
);
  localparam int PtrWidth = $clog2(Depth);

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wptr;
  logic [PtrWidth-1:0] rptr;
  logic [PtrWidth:0]   count;
  logic                push_en;
  logic                pop_en;

  assign full    = (count == (PtrWidth+1)'(Depth));
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  // Empty head reads as zero so data outputs are clean after reset.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) wptr <= wptr + 1'b1;
      if (pop_en)  rptr <= rptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wptr] <= din;
  end

endmodule

// File: rtl/pe_noc_endpoint.sv
// rtl/pe_noc_endpoint.sv - PE-side NoC endpoint: flit packing, address check, counters
module pe_noc_endpoint
  import noc_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 4,
  parameter int MyAddr    = 0,
  parameter int FifoDepth = 4
) (
  input  logic                           i_sclk,
  input  logic                           i_reset,
  input  logic [DataWidth-1:0]           i_tx_data,
  input  logic [AddrWidth-1:0]           i_tx_dest,
  input  logic                           i_tx_valid,
  output logic                           o_tx_ready,
  output logic [DataWidth+AddrWidth-1:0] o_noc_data,
  output logic                           o_noc_data_valid,
  input  logic                           i_noc_data_ready,
  input  logic [DataWidth+AddrWidth-1:0] i_noc_data,
  input  logic                           i_noc_data_valid,
  output logic                           o_noc_data_ready,
  output logic [DataWidth-1:0]           o_rx_data,
  output logic                           o_rx_valid,
  input  logic                           i_rx_ready,
  output logic [CountWidth-1:0]          o_tx_count,
  output logic [CountWidth-1:0]          o_rx_count,
  output logic                           o_addr_err
);
  localparam int FlitWidth = DataWidth + AddrWidth;
  localparam int AddrMsb   = addr_msb(DataWidth, AddrWidth);
  localparam int AddrLsb   = addr_lsb(DataWidth);

  logic alive;
  logic tx_full, tx_empty, tx_push, tx_pop;
  logic rx_full, rx_empty, rx_xfer, rx_push, rx_pop, addr_ok;

  // Readies stay low during reset and rise on the first edge after release.
  assign o_tx_ready       = alive & ~tx_full;
  assign o_noc_data_ready = alive & ~rx_full;
  assign o_noc_data_valid = ~tx_empty;
  assign o_rx_valid       = ~rx_empty;

  assign tx_push = i_tx_valid & o_tx_ready;
  assign tx_pop  = o_noc_data_valid & i_noc_data_ready;
  assign rx_xfer = i_noc_data_valid & o_noc_data_ready;
  assign addr_ok = (i_noc_data[AddrMsb:AddrLsb] == AddrWidth'(MyAddr));
  assign rx_push = rx_xfer & addr_ok;
  assign rx_pop  = o_rx_valid & i_rx_ready;

  pe_ep_fifo #(.Width(FlitWidth), .Depth(FifoDepth)) u_tx_fifo (
    .clk   (i_sclk),
    .rst_n (i_reset),
    .push  (tx_push),
    .din   ({i_tx_dest, i_tx_data}),
    .full  (tx_full),
    .pop   (tx_pop),
    .dout  (o_noc_data),
    .empty (tx_empty)
  );

  pe_ep_fifo #(.Width(DataWidth), .Depth(FifoDepth)) u_rx_fifo (
    .clk   (i_sclk),
    .rst_n (i_reset),
    .push  (rx_push),
    .din   (i_noc_data[DataWidth-1:0]),
    .full  (rx_full),
    .pop   (rx_pop),
    .dout  (o_rx_data),
    .empty (rx_empty)
  );

  always_ff @(posedge i_sclk or negedge i_reset) begin
    if (!i_reset) begin
      alive      <= 1'b0;
      o_tx_count <= '0;
      o_rx_count <= '0;
      o_addr_err <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (tx_pop)             o_tx_count <= sat_inc(o_tx_count);
      if (rx_push)            o_rx_count <= sat_inc(o_rx_count);
      if (rx_xfer && !addr_ok) o_addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_noc_endpoint.sv
// tb/tb_pe_noc_endpoint.sv - directed vector bench for pe_noc_endpoint with MyAddr=5
module tb_pe_noc_endpoint;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tx_data;
  logic [3:0]  tx_dest;
  logic        tx_valid;
  logic        tx_ready;
  logic [35:0] noc_out;
  logic        noc_out_valid;
  logic        noc_out_ready;
  logic [35:0] noc_in;
  logic        noc_in_valid;
  logic        noc_in_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] tx_count;
  logic [15:0] rx_count;
  logic        addr_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] m_tx = 0;
  logic [15:0] m_rx = 0;
  logic        m_err = 0;

  always #5 clk = ~clk;

  pe_noc_endpoint #(.DataWidth(32), .AddrWidth(4), .MyAddr(5), .FifoDepth(4)) dut (
    .i_sclk           (clk),
    .i_reset          (rst_n),
    .i_tx_data        (tx_data),
    .i_tx_dest        (tx_dest),
    .i_tx_valid       (tx_valid),
    .o_tx_ready       (tx_ready),
    .o_noc_data       (noc_out),
    .o_noc_data_valid (noc_out_valid),
    .i_noc_data_ready (noc_out_ready),
    .i_noc_data       (noc_in),
    .i_noc_data_valid (noc_in_valid),
    .o_noc_data_ready (noc_in_ready),
    .o_rx_data        (rx_data),
    .o_rx_valid       (rx_valid),
    .i_rx_ready       (rx_ready),
    .o_tx_count       (tx_count),
    .o_rx_count       (rx_count),
    .o_addr_err       (addr_err)
  );

  typedef struct {
    logic [3:0]  dest;
    logic [31:0] data;
    logic [35:0] flit_in;
    logic [35:0] exp_flit;
    logic        exp_rx_valid;
    logic [31:0] exp_rx_data;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    tx_valid      = 1'b0;
    tx_data       = '0;
    tx_dest       = '0;
    noc_in_valid  = 1'b0;
    noc_in        = '0;
    noc_out_ready = 1'b0;
    rx_ready      = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'h3, 32'hDEADBEEF, 36'h5CAFEF00D, 36'h3DEADBEEF, 1'b1, 32'hCAFEF00D};
    vecs[1] = '{4'h5, 32'h00000000, 36'h712345678, 36'h500000000, 1'b0, 32'h0};
    vecs[2] = '{4'hF, 32'hFFFFFFFF, 36'h500000000, 36'hFFFFFFFFF, 1'b1, 32'h00000000};
    vecs[3] = '{4'h5, 32'h12345678, 36'hF00000001, 36'h512345678, 1'b0, 32'h0};
    vecs[4] = '{4'h0, 32'hA5A5A5A5, 36'h5FFFFFFFF, 36'h0A5A5A5A5, 1'b1, 32'hFFFFFFFF};

    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_noc_in_ready", noc_in_ready, 0);
    chk("rst_valids", {noc_out_valid, rx_valid}, 0);
    chk("rst_counts", {tx_count, rx_count, addr_err}, 0);
    chk("rst_data", {noc_out, rx_data}, 0);
    rst_n = 1'b1;
    step();
    chk("rel_readies", {tx_ready, noc_in_ready}, 2'b11);

    // Table: one TX flit and one RX flit in the same cycle, checked, then drained.
    for (int i = 0; i < 5; i++) begin
      tx_valid     = 1'b1;
      tx_dest      = vecs[i].dest;
      tx_data      = vecs[i].data;
      noc_in_valid = 1'b1;
      noc_in       = vecs[i].flit_in;
      step();
      tx_valid     = 1'b0;
      noc_in_valid = 1'b0;
      if (!vecs[i].exp_rx_valid) m_err = 1'b1;
      else m_rx = m_rx + 1'b1;
      chk($sformatf("v%0d_noc_valid", i), noc_out_valid, 1);
      chk($sformatf("v%0d_noc_data", i), noc_out, vecs[i].exp_flit);
      chk($sformatf("v%0d_rx_valid", i), rx_valid, vecs[i].exp_rx_valid);
      chk($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx_data);
      chk($sformatf("v%0d_rx_count", i), rx_count, m_rx);
      chk($sformatf("v%0d_addr_err", i), addr_err, m_err);
      chk($sformatf("v%0d_noc_in_ready", i), noc_in_ready, 1);
      noc_out_ready = 1'b1;
      rx_ready      = 1'b1;
      step();
      m_tx = m_tx + 1'b1;
      noc_out_ready = 1'b0;
      rx_ready      = 1'b0;
      chk($sformatf("v%0d_tx_count", i), tx_count, m_tx);
      chk($sformatf("v%0d_drained", i), {noc_out_valid, rx_valid}, 0);
    end

    // Backpressure: four fill the FIFO, the fifth waits for a free slot.
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1;
      tx_dest  = 4'h2;
      tx_data  = 32'h100 + i;
      chk($sformatf("bp_ready_%0d", i), tx_ready, (i < 4) ? 1 : 0);
      if (i < 4) step();
    end
    noc_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), noc_out_valid, 1);
      chk($sformatf("bp_data_%0d", k), noc_out, {4'h2, 32'h100 + k});
      if (k == 1) chk("bp_ready_slot", tx_ready, 1);
      if (tx_valid && tx_ready) begin
        step();
        tx_valid = 1'b0;
      end else begin
        step();
      end
      m_tx = m_tx + 1'b1;
      chk($sformatf("bp_tx_count_%0d", k), tx_count, m_tx);
    end
    chk("bp_empty", noc_out_valid, 0);
    noc_out_ready = 1'b0;

    // Mid-stream reset with traffic in flight and the error flag set.
    tx_valid     = 1'b1;
    tx_dest      = 4'h1;
    tx_data      = 32'h55;
    noc_in_valid = 1'b1;
    noc_in       = 36'h5000000AA;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valids", {noc_out_valid, rx_valid}, 0);
    chk("mid_rst_counts", {tx_count, rx_count}, 0);
    chk("mid_rst_err", addr_err, 0);
    chk("mid_rst_readies", {tx_ready, noc_in_ready}, 0);
    chk("mid_rst_data", {noc_out, rx_data}, 0);
    idle_inputs();
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rel_before_edge", {tx_ready, noc_in_ready}, 0);
    step();
    chk("mid_rel_readies", {tx_ready, noc_in_ready}, 2'b11);

    // RX saturation at 16'hFFFF with continuous good traffic.
    noc_in_valid = 1'b1;
    noc_in       = 36'h500000001;
    rx_ready     = 1'b1;
    for (int n = 0; n < 65534; n++) @(posedge clk);
    #1;
    chk("sat_fffe", rx_count, 16'hFFFE);
    chk("sat_ready_held", noc_in_ready, 1);
    for (int n = 0; n < 3; n++) @(posedge clk);
    #1;
    chk("sat_ffff", rx_count, 16'hFFFF);
    chk("sat_no_err", addr_err, 0);
    noc_in_valid = 1'b0;
    step();
    step();
    chk("sat_drained", rx_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
